// File: rtl/msrh_csu_csr_seq_if.sv
// CSR access interfaces used by the CSR sequencer.
//   csr_rd_if : combinational read port. The master drives valid/addr and the
//               CSR file returns data in the same cycle.
//   csr_wr_if : write port. The master drives valid/addr/data; the CSR file
//               commits on the rising clock edge while valid is high.
// Handshake rule for both: a transfer happens in every cycle in which valid
// is high. There is no ready; the CSR file must always accept.
`timescale 1ns/1ps

interface csr_rd_if #(
    parameter int XLEN_W = 64
);
    logic              valid;
    logic [11:0]       addr;
    logic [XLEN_W-1:0] data;

    modport master (output valid, output addr, input  data);
    modport slave  (input  valid, input  addr, output data);
endinterface

interface csr_wr_if #(
    parameter int XLEN_W = 64
);
    logic              valid;
    logic [11:0]       addr;
    logic [XLEN_W-1:0] data;

    modport master (output valid, output addr, output data);
    modport slave  (input  valid, input  addr, input  data);
endinterface

// File: rtl/msrh_csu_csr_seq.sv
// CSR read-modify-write sequencer for CSRRW/CSRRS/CSRRC.
// One request is handled at a time: IDLE -> READ -> WRITE -> RESP -> IDLE.
//
// Ports
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   i_req_*             : request (valid/ready). Accepted when
//                         i_req_valid & o_req_ready & ~i_flush.
//                         op 01=RW, 10=RS, 11=RC, 00 behaves as RW.
//   csr_rd              : read port, asserted for one cycle in READ
//   csr_wr              : write port, asserted for at most one cycle in WRITE
//   o_resp_*/i_resp_ready : response (valid/ready), held stable until ready
//   i_flush             : pipeline kill, drops the request in flight
//   o_dbg_state         : current FSM state
//
// Valid/ready rule: a transfer occurs on a rising edge where valid and ready
// are both high; once valid is raised, the payload is held until the transfer.
`timescale 1ns/1ps

module msrh_csu_csr_seq #(
    parameter int TAG_W  = 4,
    parameter int XLEN_W = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [11:0]       i_req_addr,
    input  logic [XLEN_W-1:0] i_req_src,
    input  logic              i_req_src_zero,
    input  logic [TAG_W-1:0]  i_req_tag,

    csr_rd_if.master          csr_rd,
    csr_wr_if.master          csr_wr,

    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [XLEN_W-1:0] o_resp_data,
    output logic [TAG_W-1:0]  o_resp_tag,
    output logic              o_resp_illegal,

    input  logic              i_flush,

    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;

    logic [1:0]        op_q;
    logic [11:0]       addr_q;
    logic [XLEN_W-1:0] src_q;
    logic              src_zero_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN_W-1:0] old_q;

    logic              accept;
    logic              need_wr;
    logic              illegal;
    logic [XLEN_W-1:0] new_val;

    // Ready is masked by reset so it reads 0 for the whole reset window.
    assign o_req_ready = (state_q == S_IDLE) & ~i_reset;
    assign accept      = i_req_valid & o_req_ready & ~i_flush;

    // RS/RC with a zero source are pure reads; RW (and reserved 00) always writes.
    assign need_wr = ~((op_q == 2'b10) | (op_q == 2'b11)) | ~src_zero_q;
    // Address bits [11:10] == 11 mark a read-only CSR.
    assign illegal = need_wr & (addr_q[11:10] == 2'b11);

    always_comb begin
        new_val = src_q;
        case (op_q)
            2'b10:   new_val = old_q | src_q;
            2'b11:   new_val = old_q & ~src_q;
            default: new_val = src_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            tag_q      <= '0;
            old_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= i_req_op;
                addr_q     <= i_req_addr;
                src_q      <= i_req_src;
                src_zero_q <= i_req_src_zero;
                tag_q      <= i_req_tag;
            end
            if (state_q == S_READ) begin
                old_q <= csr_rd.data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = i_flush ? S_IDLE : S_WRITE;
            S_WRITE: state_d = i_flush ? S_IDLE : S_RESP;
            // A flush coinciding with ready still just drops the response.
            S_RESP:  if (i_flush | i_resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign csr_rd.valid = (state_q == S_READ);
    assign csr_rd.addr  = addr_q;

    // Write is suppressed combinationally by a flush in the same cycle.
    assign csr_wr.valid = (state_q == S_WRITE) & need_wr & ~illegal & ~i_flush;
    assign csr_wr.addr  = addr_q;
    assign csr_wr.data  = new_val;

    assign o_resp_valid   = (state_q == S_RESP) & ~i_flush;
    assign o_resp_data    = old_q;
    assign o_resp_tag     = tag_q;
    assign o_resp_illegal = illegal;

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_msrh_csu_csr_seq.sv
`timescale 1ns/1ps

module tb_msrh_csu_csr_seq;
  localparam int TAG_W  = 4;
  localparam int XLEN_W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic [1:0]        i_req_op = '0;
  logic [11:0]       i_req_addr = '0;
  logic [XLEN_W-1:0] i_req_src = '0;
  logic              i_req_src_zero = 1'b0;
  logic [TAG_W-1:0]  i_req_tag = '0;
  logic              o_resp_valid;
  logic              i_resp_ready = 1'b0;
  logic [XLEN_W-1:0] o_resp_data;
  logic [TAG_W-1:0]  o_resp_tag;
  logic              o_resp_illegal;
  logic              i_flush = 1'b0;
  logic [1:0]        o_dbg_state;

  csr_rd_if #(.XLEN_W(XLEN_W)) rd_if ();
  csr_wr_if #(.XLEN_W(XLEN_W)) wr_if ();

  always #5 i_clk = ~i_clk;

  msrh_csu_csr_seq #(.TAG_W(TAG_W), .XLEN_W(XLEN_W)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_op       (i_req_op),
    .i_req_addr     (i_req_addr),
    .i_req_src      (i_req_src),
    .i_req_src_zero (i_req_src_zero),
    .i_req_tag      (i_req_tag),
    .csr_rd         (rd_if),
    .csr_wr         (wr_if),
    .o_resp_valid   (o_resp_valid),
    .i_resp_ready   (i_resp_ready),
    .o_resp_data    (o_resp_data),
    .o_resp_tag     (o_resp_tag),
    .o_resp_illegal (o_resp_illegal),
    .i_flush        (i_flush),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- CSR file environment ----------------
  logic [XLEN_W-1:0] env_mem [4096];
  logic [XLEN_W-1:0] model_mem [4096];
  assign rd_if.data = env_mem[rd_if.addr];

  int wr_count = 0;
  int resp_count = 0;
  logic [XLEN_W-1:0] last_data = '0;
  logic [TAG_W-1:0]  last_tag = '0;
  logic              last_ill = 1'b0;

  // Inputs change just after the rising edge, so the negedge sees the values
  // that the next rising edge will act on.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset && wr_if.valid) begin
        env_mem[wr_if.addr] = wr_if.data;
        wr_count++;
      end
      if (!i_reset && o_resp_valid && i_resp_ready) begin
        resp_count++;
        last_data = o_resp_data;
        last_tag  = o_resp_tag;
        last_ill  = o_resp_illegal;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks one transaction by its age in cycles since acceptance:
  // age 1 = read cycle, age 2 = write cycle, age >= 3 = response offered.
  logic              m_busy = 1'b0;
  int                m_age = 0;
  logic [11:0]       m_addr = '0;
  logic [TAG_W-1:0]  m_tag = '0;
  logic [XLEN_W-1:0] m_old = '0;
  logic [XLEN_W-1:0] m_new = '0;
  logic              m_need = 1'b0;
  logic              m_ill = 1'b0;

  function automatic logic [XLEN_W-1:0] calc_new(input logic [1:0] op,
                                                 input logic [XLEN_W-1:0] old,
                                                 input logic [XLEN_W-1:0] src);
    if (op == 2'b10) return old | src;
    if (op == 2'b11) return old & ~src;
    return src;
  endfunction

  initial begin
    forever begin
      @(posedge i_clk);
      if (i_reset) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (i_req_valid && !i_flush) begin
          m_busy = 1'b1;
          m_age  = 1;
          m_addr = i_req_addr;
          m_tag  = i_req_tag;
          m_old  = model_mem[i_req_addr];
          m_new  = calc_new(i_req_op, m_old, i_req_src);
          m_need = (i_req_op == 2'b00) || (i_req_op == 2'b01) || !i_req_src_zero;
          m_ill  = m_need && (i_req_addr >= 12'hC00);
        end
      end else if (i_flush) begin
        m_busy = 1'b0;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        if (m_need && !m_ill) model_mem[m_addr] = m_new;
        m_age = 3;
      end else if (i_resp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        chk("rst_ready", o_req_ready, 0);
        chk("rst_rd_valid", rd_if.valid, 0);
        chk("rst_wr_valid", wr_if.valid, 0);
        chk("rst_resp_valid", o_resp_valid, 0);
        chk("rst_resp_data", o_resp_data, 0);
        chk("rst_resp_tag", o_resp_tag, 0);
        chk("rst_resp_illegal", o_resp_illegal, 0);
      end else begin
        logic e_rd, e_wr, e_resp;
        e_rd   = m_busy && (m_age == 1);
        e_wr   = m_busy && (m_age == 2) && m_need && !m_ill && !i_flush;
        e_resp = m_busy && (m_age >= 3) && !i_flush;
        chk("req_ready", o_req_ready, !m_busy);
        chk("rd_valid", rd_if.valid, e_rd);
        if (e_rd) chk("rd_addr", rd_if.addr, m_addr);
        chk("wr_valid", wr_if.valid, e_wr);
        if (e_wr) begin
          chk("wr_addr", wr_if.addr, m_addr);
          chk("wr_data", wr_if.data, m_new);
        end
        chk("resp_valid", o_resp_valid, e_resp);
        if (e_resp) begin
          chk("resp_data", o_resp_data, m_old);
          chk("resp_tag", o_resp_tag, m_tag);
          chk("resp_illegal", o_resp_illegal, m_ill);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [XLEN_W-1:0] v);
    env_mem[a]   = v;
    model_mem[a] = v;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!o_req_ready && n < 20) begin
      cyc();
      n++;
    end
    ok = o_req_ready;
    if (!ok) chk("ready_wait_timeout", o_req_ready, 1);
  endtask

  // flush_age: 0 none, 1 flush in READ, 2 in WRITE, 3 in RESP.
  task automatic run_txn(input logic [1:0] op, input logic [11:0] addr,
                         input logic [XLEN_W-1:0] src, input logic srcz,
                         input logic [TAG_W-1:0] tag, input int flush_age,
                         input int bp);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    i_req_valid    = 1'b1;
    i_req_op       = op;
    i_req_addr     = addr;
    i_req_src      = src;
    i_req_src_zero = srcz;
    i_req_tag      = tag;
    i_resp_ready   = 1'b0;
    cyc();
    // Scramble the request bus so the DUT must rely on its latched copy.
    i_req_valid    = 1'b0;
    i_req_op       = 2'($urandom);
    i_req_addr     = 12'($urandom);
    i_req_src      = $urandom;
    i_req_src_zero = 1'($urandom);
    i_req_tag      = TAG_W'($urandom);
    if (flush_age == 1) begin
      i_flush = 1'b1; cyc(); i_flush = 1'b0;
      return;
    end
    cyc();
    if (flush_age == 2) begin
      i_flush = 1'b1; cyc(); i_flush = 1'b0;
      return;
    end
    cyc();
    if (flush_age == 3) begin
      i_flush = 1'b1;
      i_resp_ready = 1'($urandom_range(0, 1));
      cyc();
      i_flush = 1'b0;
      i_resp_ready = 1'b0;
      return;
    end
    repeat (bp) cyc();
    i_resp_ready = 1'b1;
    cyc();
    i_resp_ready = 1'b0;
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0, r0;
    bit ok;
    for (int i = 0; i < 4096; i++) begin
      env_mem[i]   = $urandom;
      model_mem[i] = env_mem[i];
    end

    // Reset state
    cyc();
    chk("reset_ready", o_req_ready, 0);
    chk("reset_dbg_state", o_dbg_state, 0);
    chk("reset_resp_valid", o_resp_valid, 0);
    cyc();
    i_reset = 1'b0;
    cyc();
    chk("ready_after_reset", o_req_ready, 1);

    // RS: 0x1 | 0x8 -> 0x9, old value returned
    set_csr(12'h300, 32'h1);
    w0 = wr_count; r0 = resp_count;
    run_txn(2'b10, 12'h300, 32'h8, 1'b0, 4'h5, 0, 0);
    chk("rs_csr_value", env_mem[12'h300], 32'h9);
    chk("rs_wr_count", wr_count - w0, 1);
    chk("rs_resp_data", last_data, 32'h1);
    chk("rs_resp_tag", last_tag, 4'h5);
    chk("rs_resp_illegal", last_ill, 0);
    chk("rs_resp_count", resp_count - r0, 1);

    // RC with zero source: read only
    set_csr(12'h305, 32'hFF);
    w0 = wr_count; r0 = resp_count;
    run_txn(2'b11, 12'h305, 32'h0, 1'b1, 4'h9, 0, 0);
    chk("rc_nowr_count", wr_count - w0, 0);
    chk("rc_resp_data", last_data, 32'hFF);
    chk("rc_csr_value", env_mem[12'h305], 32'hFF);

    // RW to read-only CSR
    set_csr(12'hC00, 32'h1234);
    w0 = wr_count;
    run_txn(2'b01, 12'hC00, 32'hDEAD, 1'b0, 4'h3, 0, 0);
    chk("ro_wr_count", wr_count - w0, 0);
    chk("ro_resp_illegal", last_ill, 1);
    chk("ro_resp_data", last_data, 32'h1234);

    // Flush in WRITE
    w0 = wr_count; r0 = resp_count;
    run_txn(2'b01, 12'h340, 32'hCAFE, 1'b0, 4'h1, 2, 0);
    chk("flush_wr_ready_next", o_req_ready, 1);
    chk("flush_wr_count", wr_count - w0, 0);
    chk("flush_wr_resp_count", resp_count - r0, 0);

    // Backpressure: 5 cycles stalled, done on the 6th
    set_csr(12'h341, 32'h55);
    r0 = resp_count;
    run_txn(2'b10, 12'h341, 32'hA0, 1'b0, 4'hB, 0, 5);
    chk("bp_resp_count", resp_count - r0, 1);
    chk("bp_resp_data", last_data, 32'h55);
    chk("bp_resp_tag", last_tag, 4'hB);
    chk("bp_ready_after", o_req_ready, 1);

    // Reset in the middle of READ
    set_csr(12'h310, 32'h77);
    wait_ready(ok);
    if (ok) begin
      w0 = wr_count; r0 = resp_count;
      i_req_valid = 1'b1; i_req_op = 2'b01; i_req_addr = 12'h310;
      i_req_src = 32'hABCD; i_req_src_zero = 1'b0; i_req_tag = 4'h7;
      cyc();
      i_req_valid = 1'b0;
      #2 i_reset = 1'b1;
      #1;
      chk("midrst_ready", o_req_ready, 0);
      chk("midrst_rd_valid", rd_if.valid, 0);
      chk("midrst_wr_valid", wr_if.valid, 0);
      chk("midrst_resp_valid", o_resp_valid, 0);
      chk("midrst_resp_data", o_resp_data, 0);
      chk("midrst_resp_tag", o_resp_tag, 0);
      chk("midrst_resp_illegal", o_resp_illegal, 0);
      cyc();
      #2 i_reset = 1'b0;
      repeat (6) cyc();
      chk("midrst_wr_count", wr_count - w0, 0);
      chk("midrst_resp_count", resp_count - r0, 0);
      chk("midrst_csr_value", env_mem[12'h310], 32'h77);
      chk("midrst_ready_after", o_req_ready, 1);
    end

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      logic [1:0]        op;
      logic [11:0]       addr;
      logic [XLEN_W-1:0] src;
      logic              srcz;
      int                fa;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: addr = 12'h300;
        1: addr = 12'h305;
        2: addr = 12'h340;
        3: addr = 12'hC00;
        4: addr = 12'hC01;
        5: addr = 12'h7C0;
        default: addr = 12'($urandom);
      endcase
      srcz = ($urandom_range(0, 3) == 0);
      src  = srcz ? '0 : $urandom;
      fa   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      if ($urandom_range(0, 9) == 0) begin
        // A flush while idle must block acceptance.
        i_req_valid = 1'b1; i_flush = 1'b1;
        i_req_op = op; i_req_addr = addr; i_req_src = src;
        i_req_src_zero = srcz; i_req_tag = TAG_W'($urandom);
        cyc();
        i_req_valid = 1'b0; i_flush = 1'b0;
      end
      run_txn(op, addr, src, srcz, TAG_W'($urandom), fa, $urandom_range(0, 3));
    end

    repeat (3) cyc();
    finish_run();
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    finish_run();
  end

endmodule
